// File: rtl/csa_stream_xor_ctrl_if.sv
// Bundle of the payload-in, cypher and payload-out signals around the CSA stream XOR controller.
// The master side is the controller; the slave side is its environment (splitter, cypher, block layer).
interface csa_stream_xor_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [3:0]  in_bytes;
    logic        in_last;

    logic        sc_init;
    logic        sc_en;
    logic [63:0] sc_sb;
    logic [63:0] sc_cb;

    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_bytes;
    logic        out_first;
    logic        out_last;

    modport master (
        input  in_valid, in_data, in_bytes, in_last, sc_cb, out_ready,
        output in_ready, sc_init, sc_en, sc_sb,
        output out_valid, out_data, out_bytes, out_first, out_last
    );

    modport slave (
        output in_valid, in_data, in_bytes, in_last, sc_cb, out_ready,
        input  in_ready, sc_init, sc_en, sc_sb,
        input  out_valid, out_data, out_bytes, out_first, out_last
    );
endinterface

// File: rtl/csa_stream_xor_ctrl.sv
// CSA stream-layer controller: feeds 64-bit payload blocks to the stream cypher and XORs
// full non-first blocks with the returned keystream; one block in flight at a time.
module csa_stream_xor_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    csa_stream_xor_ctrl_if.master bus,
    output logic [CNT_W-1:0]      pkt_count
);

    localparam int unsigned BLK_BYTES = 8;
    localparam int unsigned BYTES_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KS   = 2'd1,
        ST_XOR  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [BYTES_W-1:0] blk_bytes;
    logic               blk_last;
    logic               blk_first;
    logic               first_flag;

    logic               accept_c;
    logic               full_in_c;
    logic [BYTES_W-1:0] eff_bytes_c;

    logic               in_ready_nxt;
    logic               sc_en_nxt;
    logic               sc_init_nxt;
    logic [63:0]        out_data_nxt;

    // Out-of-range byte counts (0 or above 8) are handled as a full block.
    always_comb begin
        eff_bytes_c = bus.in_bytes;
        if (bus.in_bytes == '0 || bus.in_bytes > BYTES_W'(BLK_BYTES)) begin
            eff_bytes_c = BYTES_W'(BLK_BYTES);
        end
    end

    assign full_in_c = (eff_bytes_c == BYTES_W'(BLK_BYTES));
    assign accept_c  = bus.in_valid & bus.in_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept_c)      state_nxt = ST_KS;
            ST_KS:                      state_nxt = ST_XOR;
            ST_XOR:                     state_nxt = ST_OUT;
            ST_OUT:  if (bus.out_ready) state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered control outputs and the output block
    always_comb begin
        in_ready_nxt = (state_nxt == ST_IDLE);
        sc_en_nxt    = 1'b0;
        sc_init_nxt  = 1'b0;
        if (state == ST_IDLE && accept_c) begin
            // Partial blocks leave the cypher state untouched.
            sc_en_nxt   = full_in_c;
            sc_init_nxt = full_in_c & first_flag;
        end

        // The first block only seeds the cypher, so its keystream is never applied.
        out_data_nxt = bus.sc_sb;
        if (blk_bytes == BYTES_W'(BLK_BYTES) && !blk_first) begin
            out_data_nxt = bus.sc_sb ^ bus.sc_cb;
        end
        for (int unsigned i = 0; i < BLK_BYTES; i++) begin
            if (BYTES_W'(i) >= blk_bytes) begin
                out_data_nxt[i*8 +: 8] = 8'h00;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.in_ready  <= 1'b1;
            bus.sc_init   <= 1'b0;
            bus.sc_en     <= 1'b0;
            bus.sc_sb     <= '0;
            blk_bytes     <= '0;
            blk_last      <= 1'b0;
            blk_first     <= 1'b0;
            first_flag    <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_bytes <= '0;
            bus.out_first <= 1'b0;
            bus.out_last  <= 1'b0;
            pkt_count     <= '0;
        end else begin
            bus.in_ready <= in_ready_nxt;
            bus.sc_en    <= sc_en_nxt;
            bus.sc_init  <= sc_init_nxt;

            if (state == ST_IDLE && accept_c) begin
                bus.sc_sb <= bus.in_data;
                blk_bytes <= eff_bytes_c;
                blk_last  <= bus.in_last | ~full_in_c;
                blk_first <= first_flag;
            end

            if (state == ST_XOR) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= out_data_nxt;
                bus.out_bytes <= blk_bytes;
                bus.out_first <= blk_first;
                bus.out_last  <= blk_last;
            end

            if (state == ST_OUT && bus.out_ready) begin
                bus.out_valid <= 1'b0;
                if (blk_last) begin
                    first_flag <= 1'b1;
                    pkt_count  <= pkt_count + CNT_W'(1);
                end else begin
                    first_flag <= 1'b0;
                end
            end
        end
    end

endmodule
